// File: rtl/serial_adder_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | serial_adder_ctrl : bit-serial adder, one full-adder cell, LSB first|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+

module full_adder_dataflow (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [CW-1:0] c_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q,   cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;

    logic w_fa_s;
    logic w_fa_cout;

    full_adder_dataflow u_fa (
        .a    (a_q[cnt_q]),
        .b    (b_q[cnt_q]),
        .cin  (carry_q),
        .s    (w_fa_s),
        .cout (w_fa_cout)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = c_RUN;
                end
            end
            c_RUN: begin
                res_d[cnt_q] = w_fa_s;
                carry_d      = w_fa_cout;
                // Last bit: publish result this edge; cnt stays at WIDTH-1.
                if (cnt_q == c_LAST) begin
                    sum_d   = res_d;
                    cout_d  = w_fa_cout;
                    state_d = c_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q == c_RUN);
    assign done = (state_q == c_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_serial_adder_ctrl : three DUTs (WIDTH 2/8/17) vs arithmetic model|
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_serial_adder_ctrl;

    logic clk;
    logic rst_n;

    int checks;
    int failures;

    logic        start_v [3];
    logic [63:0] a_v     [3];
    logic [63:0] b_v     [3];
    logic        cin_v   [3];
    wire         busy_w  [3];
    wire         done_w  [3];
    wire         cout_w  [3];
    wire  [63:0] sum_w   [3];
    wire  [1:0]  sum2;
    wire  [7:0]  sum8;
    wire  [16:0] sum17;

    logic [63:0] prev_sum  [3];
    logic        prev_cout [3];

    assign sum_w[0] = {62'd0, sum2};
    assign sum_w[1] = {56'd0, sum8};
    assign sum_w[2] = {47'd0, sum17};

    serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]),
        .a(a_v[0][1:0]), .b(b_v[0][1:0]), .cin(cin_v[0]),
        .busy(busy_w[0]), .done(done_w[0]), .sum(sum2), .cout(cout_w[0])
    );

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .cin(cin_v[1]),
        .busy(busy_w[1]), .done(done_w[1]), .sum(sum8), .cout(cout_w[1])
    );

    serial_adder_ctrl #(.WIDTH(17)) u_dut17 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]),
        .a(a_v[2][16:0]), .b(b_v[2][16:0]), .cin(cin_v[2]),
        .busy(busy_w[2]), .done(done_w[2]), .sum(sum17), .cout(cout_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One operation on DUT k; the model is plain (a+b+cin) arithmetic and cycle counting.
    task automatic do_op(input int k, input int w, input logic [63:0] av,
                         input logic [63:0] bv, input logic cv, input bit noisy);
        logic [63:0] mask;
        logic [63:0] full;
        int          busy_n;
        int          lat;
        bit          got;
        mask = (64'd1 << w) - 64'd1;
        full = (av & mask) + (bv & mask) + {63'd0, cv};
        @(negedge clk);
        start_v[k] = 1'b1; a_v[k] = av; b_v[k] = bv; cin_v[k] = cv;
        @(posedge clk); #1;
        start_v[k] = noisy;
        a_v[k] = {$urandom, $urandom}; b_v[k] = {$urandom, $urandom};
        cin_v[k] = 1'($urandom_range(0, 1));
        check_eq("busy_after_accept", {63'd0, busy_w[k]}, 64'd1);
        busy_n = 1; lat = 0; got = 0;
        for (int c = 1; c <= w + 2 && !got; c++) begin
            @(posedge clk); #1;
            if (noisy) begin
                a_v[k] = {$urandom, $urandom}; b_v[k] = {$urandom, $urandom};
            end
            if (done_w[k]) begin
                got = 1; lat = c;
            end else begin
                check_eq("sum_hold", sum_w[k], prev_sum[k]);
                check_eq("cout_hold", {63'd0, cout_w[k]}, {63'd0, prev_cout[k]});
                if (busy_w[k]) busy_n++;
            end
        end
        start_v[k] = 1'b0;
        check_eq("done_latency", got ? 64'(lat) : 64'd0, 64'(w));
        check_eq("busy_cycles", 64'(busy_n), 64'(w));
        check_eq("sum", sum_w[k], full & mask);
        check_eq("cout", {63'd0, cout_w[k]}, (full >> w) & 64'd1);
        prev_sum[k]  = full & mask;
        prev_cout[k] = full[w];
        @(posedge clk); #1;
        check_eq("done_one_cycle", {63'd0, done_w[k]}, 64'd0);
    endtask

    task automatic run_back_to_back();
        logic [7:0] opa  [3];
        logic [7:0] opb  [3];
        logic [7:0] exps [3];
        logic       expc [3];
        int         idx;
        opa = '{8'h01, 8'h10, 8'h80};
        opb = '{8'h02, 8'h20, 8'h80};
        exps = '{8'h03, 8'h30, 8'h00};
        expc = '{1'b0, 1'b0, 1'b1};
        idx = 0;
        @(negedge clk);
        start_v[1] = 1'b1; a_v[1] = {56'd0, opa[0]}; b_v[1] = {56'd0, opb[0]}; cin_v[1] = 1'b0;
        for (int t = 1; t <= 40 && idx < 3; t++) begin
            @(posedge clk); #1;
            if (done_w[1]) begin
                check_eq("b2b_done_time", 64'(t), 64'(9 + 10 * idx));
                check_eq("b2b_sum", sum_w[1], {56'd0, exps[idx]});
                check_eq("b2b_cout", {63'd0, cout_w[1]}, {63'd0, expc[idx]});
                prev_sum[1]  = {56'd0, exps[idx]};
                prev_cout[1] = expc[idx];
                idx++;
                if (idx < 3) begin
                    a_v[1] = {56'd0, opa[idx]}; b_v[1] = {56'd0, opb[idx]};
                end else begin
                    start_v[1] = 1'b0;
                end
            end else begin
                check_eq("b2b_sum_hold", sum_w[1], prev_sum[1]);
            end
        end
        check_eq("b2b_count", 64'(idx), 64'd3);
        @(posedge clk); #1;
    endtask

    task automatic run_random(input int k, input int w, input int n);
        logic [63:0] ra;
        logic [63:0] rb;
        for (int i = 0; i < n; i++) begin
            ra = (i % 40 == 0) ? '1 : {$urandom, $urandom};
            rb = (i % 40 == 1) ? '1 : {$urandom, $urandom};
            do_op(k, w, ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
        end
    endtask

    initial begin
        bit seen;
        checks = 0; failures = 0;
        for (int k = 0; k < 3; k++) begin
            start_v[k] = 1'b0; a_v[k] = '0; b_v[k] = '0; cin_v[k] = 1'b0;
            prev_sum[k] = '0; prev_cout[k] = 1'b0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_eq("reset_sum", sum_w[1], 64'd0);
        check_eq("reset_cout", {63'd0, cout_w[1]}, 64'd0);
        check_eq("reset_busy", {63'd0, busy_w[1]}, 64'd0);
        check_eq("reset_done", {63'd0, done_w[1]}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        do_op(1, 8, 64'h5A, 64'hA5, 1'b0, 0);
        do_op(1, 8, 64'hFF, 64'h01, 1'b0, 0);
        do_op(1, 8, 64'hFF, 64'hFF, 1'b1, 1);
        run_back_to_back();

        // Abort 0x0F+0x01 with bits 0..3 processed; reset lands mid-cycle.
        @(negedge clk);
        start_v[1] = 1'b1; a_v[1] = 64'h0F; b_v[1] = 64'h01; cin_v[1] = 1'b0;
        @(posedge clk); #1 start_v[1] = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("abort_sum", sum_w[1], 64'd0);
        check_eq("abort_cout", {63'd0, cout_w[1]}, 64'd0);
        check_eq("abort_busy", {63'd0, busy_w[1]}, 64'd0);
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done_w[1]) seen = 1;
        end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            prev_sum[k] = '0; prev_cout[k] = 1'b0;
        end
        repeat (10) begin
            @(posedge clk); #1;
            if (done_w[1]) seen = 1;
        end
        check_eq("abort_no_done", {63'd0, seen}, 64'd0);
        do_op(1, 8, 64'h0F, 64'h01, 1'b0, 0);

        fork
            run_random(0, 2, 1000);
            run_random(1, 8, 1000);
            run_random(2, 17, 1000);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
